// File: rtl/cla_seq_ctrl_if.sv
// Request/result bundle of the sequential 128-bit carry-lookahead add/subtract unit.
// start is a request sampled only while not busy; busy is the inverse of ready; done pulses for one cycle with sum/cout/ovf valid and held afterwards.
interface cla_seq_ctrl_if;
    logic         start;
    logic         sub;
    logic         cin;
    logic [127:0] A;
    logic [127:0] B;
    logic         busy;
    logic         done;
    logic [127:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cin, A, B,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, A, B,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Sequential 128-bit add/subtract: one shared 32-bit carry-lookahead adder processes
// one word per cycle, LSW first. state_dbg exposes the FSM (IDLE=0, RUN=1, DONE=2).
module CarryLookAheadAdder32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [31:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 8; k++) begin
            grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
    end

    // Group carries are each a closed-form function of group G/P and cin.
    always_comb begin
        logic acc;
        grp_c = '0;
        grp_c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            acc = cin;
            for (int j = 0; j <= k; j++) begin
                acc = grp_g[j] | (grp_p[j] & acc);
            end
            grp_c[k+1] = acc;
        end
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    assign s    = p ^ c;
    assign cout = grp_c[8];
endmodule

module cla_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    cla_seq_ctrl_if.slave  bus,
    output logic [1:0]     state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] a_q;
    logic [127:0] b_q;
    logic         carry_q;
    logic [1:0]   idx;
    logic [95:0]  part_q;
    logic [127:0] sum_q;
    logic         cout_q;
    logic         ovf_q;
    logic [31:0]  a_word;
    logic [31:0]  b_word;
    logic [31:0]  add_s;
    logic         add_c;
    logic         accept;

    always_comb begin
        a_word = a_q[31:0];
        b_word = b_q[31:0];
        case (idx)
            2'd0: begin a_word = a_q[31:0];   b_word = b_q[31:0];   end
            2'd1: begin a_word = a_q[63:32];  b_word = b_q[63:32];  end
            2'd2: begin a_word = a_q[95:64];  b_word = b_q[95:64];  end
            default: begin a_word = a_q[127:96]; b_word = b_q[127:96]; end
        endcase
    end

    CarryLookAheadAdder32bit u_cla (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_c)
    );

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (idx == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so inversion and the forced carry happen at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= 2'd0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.A;
            b_q     <= bus.sub ? ~bus.B : bus.B;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx     <= 2'd0;
        end else if (state == RUN) begin
            carry_q <= add_c;
            idx     <= idx + 2'd1;
            case (idx)
                2'd0: part_q[31:0]  <= add_s;
                2'd1: part_q[63:32] <= add_s;
                2'd2: part_q[95:64] <= add_s;
                default: begin
                    sum_q  <= {add_s, part_q};
                    cout_q <= add_c;
                    ovf_q  <= (a_q[127] == b_q[127]) && (add_s[31] != a_q[127]);
                end
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign state_dbg = state;
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters: none; operand width fixed at 128 bits, 32-bit word slice, 4 words.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled at a rising edge.
REQ-005 sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored).
REQ-006 cin  input  1  carry-in for add.
REQ-007 A  input  128  operand A; sampled only at the edge that accepts start.
REQ-008 B  input  128  operand B; sampled only at the edge that accepts start.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  128  registered result.
REQ-012 cout  output  1  carry out of bit 127.
REQ-013 ovf  output  1  signed two's-complement overflow.

Function
REQ-014 The block SHALL contain exactly one CarryLookAheadAdder32bit instance; all arithmetic SHALL pass through it, one 32-bit word per cycle, LSW first.
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; encoding is free.
REQ-016 IDLE or DONE, start=1: capture A; capture B (or ~B when sub=1); set carry register to cin (or 1 when sub=1); word index to 0; go to RUN.
REQ-017 DONE, start=0: go to IDLE; IDLE, start=0: stay.
REQ-018 In RUN, each edge: adder inputs SHALL be captured A word[idx], captured B word[idx], carry register; partial-result word[idx] SHALL take adder sum; carry register SHALL take adder cout; idx SHALL increment.
REQ-019 In RUN with idx=3: the edge SHALL also load sum with the full 128-bit result, cout with the adder cout, ovf, and go to DONE.
REQ-020 ovf SHALL equal (A[127] == Bop[127]) AND (sum[127] != A[127]), where Bop is the captured, possibly inverted, B.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 Latency: start accepted at edge E0 -> busy high for the 4 cycles after E0 -> done high for the single cycle after E4.
REQ-023 start while in RUN SHALL be ignored; no queuing, no state change.
REQ-024 A, B, sub, cin changes after acceptance SHALL NOT affect the operation in progress.
REQ-025 sum, cout and ovf SHALL hold their last completed values until the next completion; partial words SHALL never be visible on sum.
REQ-026 start in DONE SHALL be accepted (back-to-back throughput of one operation per 5 cycles).

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, idx=0, carry register=0, from any state, including mid-RUN.
REQ-028 rst SHALL take priority over start at the same edge; the start SHALL be dropped.
REQ-029 The first edge with rst=0 and start=1 SHALL begin a normal operation.

Verification
REQ-030 A=1, B=1, cin=0, sub=0 -> done 4 cycles after the start edge; sum=2, cout=0, ovf=0; busy high exactly 4 cycles.
REQ-031 A=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1 -> sum=0x0000_0001_0000_0000_0000_0000_0000_0000, cout=0 (carry crosses 3 word boundaries).
REQ-032 A=all ones, B=0, cin=1 -> sum=0, cout=1, ovf=0; A=0x7FFF...FFFF, B=1, cin=0 -> sum=0x8000...0000, ovf=1, cout=0.
REQ-033 A=5, B=7, sub=1, cin=1 -> sum=0xFFFF...FFFE, cout=0, ovf=0; A=7, B=5, sub=1 -> sum=2, cout=1.
REQ-034 start with A=1, B=1; start again during RUN with A=9 -> ignored, result sum=2; start held in DONE with A=3, B=4 -> second done 5 cycles after first, sum=7.
REQ-035 rst pulsed after 2 RUN cycles -> next cycle busy=0, done=0, sum=0; no done pulse follows; a later start with A=10, B=20 -> sum=30.
